lstm_seq_driver: RTL and testbench

- Sequential driver on the far side of the combinational LSTM cell interface.
- Accepts a stream of X samples and owns the recurrent c/h state registers.
- Presents {x, c_in, h_in} to an external cell instance and captures {c_out, h_out} as the next state.
- Streams one h per timestep downstream and flags the last step of each sequence. The cell sits beside this block in the recurrent top level.

---
 rtl/lstm_pkg.sv | 25 ++
 rtl/lstm_seq_driver.sv | 153 +++++++++++++++
 tb/tb_lstm_seq_driver.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lstm_pkg
// Description : Shared constants, fixed-point word type and FSM encoding for
//               the LSTM sequence driver and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package lstm_pkg;

  // Default Q8.8 word geometry shared by the driver and the cell.
  localparam int c_data_width  = 16;
  localparam int c_fract_width = 8;

  // Signed fixed-point word at the default geometry.
  typedef logic signed [c_data_width-1:0] fxp_t;

  // Sequencer state encoding.
  typedef logic [1:0] state_t;
  localparam state_t c_st_idle   = 2'd0;
  localparam state_t c_st_wait_x = 2'd1;
  localparam state_t c_st_eval   = 2'd2;
  localparam state_t c_st_emit   = 2'd3;

endpackage : lstm_pkg
`default_nettype wire

// File: rtl/lstm_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : lstm_seq_driver
// Description : Sequential driver for a combinational LSTM cell. Owns the
//               recurrent c/h registers, feeds {x, c, h} to the cell, captures
//               its outputs once per timestep and streams h downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module lstm_seq_driver
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH  = c_data_width,
  parameter int FRACT_WIDTH = c_fract_width,
  parameter int LEN_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      seq_len,
  input  logic [DATA_WIDTH-1:0] c_init,
  input  logic [DATA_WIDTH-1:0] h_init,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c_in,
  output logic [DATA_WIDTH-1:0] cell_h_in,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_h,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  // The fractional split only matters to the cell; reject nonsense geometry.
  if (FRACT_WIDTH >= DATA_WIDTH || FRACT_WIDTH < 0) begin : g_bad_fract
    $error("lstm_seq_driver: FRACT_WIDTH must lie in [0, DATA_WIDTH)");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_x;
  logic [DATA_WIDTH-1:0] r_c;
  logic [DATA_WIDTH-1:0] r_h;
  logic [DATA_WIDTH-1:0] r_out_h;
  logic [LEN_W-1:0]      r_cnt;
  logic [LEN_W-1:0]      r_len;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_done;

  logic w_start_run;
  logic w_start_empty;
  logic w_take_x;
  logic w_out_hs;

  // Qualified events; abort masks every one of them.
  assign w_start_run   = !abort && (r_state == c_st_idle) && start && (seq_len != '0);
  assign w_start_empty = !abort && (r_state == c_st_idle) && start && (seq_len == '0);
  assign w_take_x      = !abort && (r_state == c_st_wait_x) && in_valid;
  assign w_out_hs      = !abort && (r_state == c_st_emit) && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort returns to IDLE from anywhere.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:   if (w_start_run) w_state_nxt = c_st_wait_x;
        c_st_wait_x: if (in_valid)    w_state_nxt = c_st_eval;
        c_st_eval:                    w_state_nxt = c_st_emit;
        c_st_emit:   if (out_ready)   w_state_nxt = r_out_last ? c_st_idle : c_st_wait_x;
        default:                      w_state_nxt = c_st_idle;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = (r_state == c_st_wait_x);
    busy     = (r_state != c_st_idle);
  end

  // Datapath: recurrent state, sample capture, output hold and step counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_c         <= '0;
      r_h         <= '0;
      r_out_h     <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_start_empty || (w_out_hs && r_out_last);
      if (abort) begin
        // c/h and the counters are deliberately left untouched.
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        if (w_start_run) begin
          r_len <= seq_len;
          r_c   <= c_init;
          r_h   <= h_init;
          r_cnt <= '0;
        end
        if (w_take_x) begin
          r_x <= in_x;
        end
        // Cell outputs are only meaningful while its inputs are the settled
        // registers of this step, so they are captured in EVAL alone.
        if (r_state == c_st_eval) begin
          r_c         <= cell_c_out;
          r_h         <= cell_h_out;
          r_out_h     <= cell_h_out;
          r_out_last  <= (r_cnt == r_len - 1'b1);
          r_out_valid <= 1'b1;
        end
        // cnt stops at len after the final step, so len = 2^LEN_W-1 never wraps.
        if (w_out_hs) begin
          r_out_valid <= 1'b0;
          r_cnt       <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign cell_x    = r_x;
  assign cell_c_in = r_c;
  assign cell_h_in = r_h;
  assign out_h     = r_out_h;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign done      = r_done;

endmodule : lstm_seq_driver
`default_nettype wire

// File: tb/tb_lstm_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_lstm_seq_driver
// Description : Directed self-checking bench for lstm_seq_driver using a stub
//               cell (c_out = c_in + x, h_out = h_in + 0x0100).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lstm_seq_driver;

  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, in_valid, out_ready;
  logic [LW-1:0] seq_len;
  logic [DW-1:0] c_init, h_init, in_x;
  logic          in_ready, out_valid, out_last, busy, done;
  logic [DW-1:0] cell_x, cell_c_in, cell_h_in, cell_c_out, cell_h_out, out_h;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stub cell.
  assign cell_c_out = cell_c_in + cell_x;
  assign cell_h_out = cell_h_in + 16'h0100;

  lstm_seq_driver #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_len(seq_len),
    .c_init(c_init), .h_init(h_init), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .cell_x(cell_x), .cell_c_in(cell_c_in), .cell_h_in(cell_h_in),
    .cell_c_out(cell_c_out), .cell_h_out(cell_h_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_h(out_h), .out_last(out_last), .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LW-1:0] len, input logic [DW-1:0] c0, input logic [DW-1:0] h0);
    start = 1'b1; seq_len = len; c_init = c0; h_init = h0;
    tick();
    start = 1'b0;
  endtask

  // One timestep: feed x, check EVAL/EMIT timing, optionally stall, handshake.
  task automatic step(input logic [DW-1:0] x, input logic [DW-1:0] exp_c,
                      input logic [DW-1:0] exp_h, input logic exp_last, input int stall);
    int guard = 0;
    while (!in_ready && guard < 8) begin
      tick();
      guard++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_x = x;
    out_ready = (stall == 0);
    tick();                                   // edge T: sample accepted
    in_valid = 1'b0;
    chk("eval_in_ready", {31'd0, in_ready}, 32'd0);
    chk("eval_out_valid", {31'd0, out_valid}, 32'd0);
    chk("eval_cell_x", {16'd0, cell_x}, {16'd0, x});
    tick();                                   // edge T+1: EVAL capture
    chk("emit_out_valid", {31'd0, out_valid}, 32'd1);
    chk("emit_out_h", {16'd0, out_h}, {16'd0, exp_h});
    chk("emit_out_last", {31'd0, out_last}, {31'd0, exp_last});
    chk("emit_in_ready", {31'd0, in_ready}, 32'd0);
    chk("emit_cell_c", {16'd0, cell_c_in}, {16'd0, exp_c});
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out_h", {16'd0, out_h}, {16'd0, exp_h});
      chk("stall_out_last", {31'd0, out_last}, {31'd0, exp_last});
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_cell_c", {16'd0, cell_c_in}, {16'd0, exp_c});
      chk("stall_cell_h", {16'd0, cell_h_in}, {16'd0, exp_h});
    end
    out_ready = 1'b1;
    tick();                                   // output handshake
    chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hs_done", {31'd0, done}, {31'd0, exp_last});
    chk("hs_busy", {31'd0, busy}, {31'd0, !exp_last});
    if (exp_last) begin
      tick();
      chk("done_once", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seq_len = '0; c_init = '0; h_init = '0; in_x = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state.
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_regs", {cell_c_in, cell_h_in}, 32'd0);
    chk("rst_x_h", {cell_x, out_h}, 32'd0);

    // Basic three-step run.
    do_start(8'd3, 16'h0000, 16'h0000);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    step(16'h0010, 16'h0010, 16'h0100, 1'b0, 0);
    step(16'h0020, 16'h0030, 16'h0200, 1'b0, 0);
    step(16'h0030, 16'h0060, 16'h0300, 1'b1, 0);
    chk("basic_final_c", {16'd0, cell_c_in}, 32'h0000_0060);
    chk("basic_final_h", {16'd0, cell_h_in}, 32'h0000_0300);

    // Backpressure on the first of two steps.
    do_start(8'd2, 16'h0100, 16'h0000);
    step(16'h0001, 16'h0101, 16'h0100, 1'b0, 5);
    step(16'h0002, 16'h0103, 16'h0200, 1'b1, 0);
    chk("bp_final_c", {16'd0, cell_c_in}, 32'h0000_0103);

    // Zero-length sequence.
    do_start(8'd0, 16'h1111, 16'h2222);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    chk("len0_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("len0_done_once", {31'd0, done}, 32'd0);
    chk("len0_busy2", {31'd0, busy}, 32'd0);

    // Abort and start together in IDLE: abort wins.
    abort = 1'b1;
    do_start(8'd3, 16'h0000, 16'h0000);
    abort = 1'b0;
    chk("abst_busy", {31'd0, busy}, 32'd0);
    chk("abst_done", {31'd0, done}, 32'd0);

    // Abort in EMIT of step 2 of 4.
    do_start(8'd4, 16'h0000, 16'h0000);
    step(16'h0001, 16'h0001, 16'h0100, 1'b0, 0);
    in_valid = 1'b1; in_x = 16'h0002; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ab_emit_valid", {31'd0, out_valid}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b1;
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ab_out_last", {31'd0, out_last}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_hold_ch", {cell_c_in, cell_h_in}, 32'h0003_0200);
    tick();
    chk("ab_done2", {31'd0, done}, 32'd0);
    do_start(8'd1, 16'h0005, 16'h0000);
    step(16'h0003, 16'h0008, 16'h0100, 1'b1, 0);

    // Reset in EVAL.
    do_start(8'd2, 16'h0007, 16'h0009);
    in_valid = 1'b1; in_x = 16'h0004;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rste_flags", {27'd0, in_ready, out_valid, out_last, busy, done}, 32'd0);
    chk("rste_ch", {cell_c_in, cell_h_in}, 32'd0);
    chk("rste_x_h", {cell_x, out_h}, 32'd0);

    // Longest sequence runs to completion without counter wrap.
    do_start(8'd255, 16'h0000, 16'h0000);
    for (int k = 1; k <= 255; k++) begin
      step(16'h0001, k[15:0], {k[7:0], 8'h00}, (k == 255), 0);
    end
    chk("max_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_lstm_seq_driver
`default_nettype wire
